// File: rtl/uart_io_port.sv
// uart_io_port: 8N1 UART peripheral on the processor's 8-bit IO port bus.
//
// Port map:
//   write 0x01 push byte to TX FIFO (dropped when full, sets tx_drop_q)
//   read  0x01 RX FIFO head (0x00 when empty); pops on IO_read_strobe
//   read  0x02 0xFF when RX FIFO non-empty, else 0x00
//   read  0x03 0xFF when TX FIFO full, else 0x00
//   other reads return 0xFF, other writes are ignored
//
// Ports:
//   clk100          single clock
//   reset           synchronous, active-high
//   IO_port_ID      port address, qualified by either strobe
//   IO_write_data   write data, qualified by IO_write_strobe
//   IO_write_strobe one-cycle write pulse
//   IO_read_strobe  one-cycle read pulse
//   IO_read_data    combinational read data
//   uart_tx         serial output, idle high
//   uart_rx         serial input, asynchronous
//
// Build option: define UART_RX_EN to build the receive path (synchroniser, RX FSM,
// RX FIFO). Without it uart_rx is unused and reads of 0x01/0x02 return 0x00.
//
// Debug flags tx_drop_q, rx_ferr_q and rx_overrun_q are sticky until reset and have
// no port; they are observed hierarchically.

module uart_io_port #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW-1:0] PtrOne   = PW'(1);

    localparam logic [7:0] PortData   = 8'h01;
    localparam logic [7:0] PortRxStat = 8'h02;
    localparam logic [7:0] PortTxStat = 8'h03;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_rptr_q;
    logic          tx_empty, tx_full, tx_wr_req, tx_push, tx_pop;
    logic          tx_drop_q;

    assign tx_empty  = (tx_wptr_q == tx_rptr_q);
    assign tx_full   = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                       (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_wr_req = IO_write_strobe && (IO_port_ID == PortData);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push   = tx_wr_req && (!tx_full || tx_pop);

    always_ff @(posedge clk100) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_drop_q <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
            if (tx_wr_req && !tx_push) tx_drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= IO_write_data;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    always_ff @(posedge clk100) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem[tx_rptr_q[AW-1:0]];
                    tx_cnt_d   = '0;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntOne;
                end
            end
            StData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 3'd7) tx_state_d = StStop;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntOne;
                end
            end
            StStop: begin
                if (tx_cnt_q == BitLast) tx_state_d = StIdle;
                else                     tx_cnt_d   = tx_cnt_q + CntOne;
            end
            default: tx_state_d = StIdle;
        endcase
    end

    // Line level is decoded from next state so uart_tx is a clean register output.
    always_comb begin
        tx_line_d = 1'b1;
        case (tx_state_d)
            StStart: tx_line_d = 1'b0;
            StData:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    assign uart_tx = tx_line_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic       rx_avail;
    logic [7:0] rx_head;

`ifdef UART_RX_EN
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_stop_done, rx_push_req, rx_ferr_set;
    logic          rx_ferr_q, rx_overrun_q;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_rptr_q;
    logic          rx_empty, rx_full, rx_push, rx_pop;

    always_ff @(posedge clk100) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // Line high again at mid start bit: treat as a glitch.
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntOne;
                end
            end
            StData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = StStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntOne;
                end
            end
            StStop: begin
                // After a framing error the line may still be low; IDLE only
                // leaves on a fresh 1->0 edge, which implies waiting for high.
                if (rx_cnt_q == BitLast) rx_state_d = StIdle;
                else                     rx_cnt_d   = rx_cnt_q + CntOne;
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_stop_done = (rx_state_q == StStop) && (rx_cnt_q == BitLast);
        rx_push_req  = rx_stop_done && rx_sync_q;
        rx_ferr_set  = rx_stop_done && !rx_sync_q;
    end

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_pop   = IO_read_strobe && (IO_port_ID == PortData) && !rx_empty;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);

    always_ff @(posedge clk100) begin
        if (reset) begin
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_ferr_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
            if (rx_ferr_set) rx_ferr_q <= 1'b1;
            if (rx_push_req && !rx_push) rx_overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    assign rx_avail = !rx_empty;
    assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];

    logic unused_rx_flags;
    assign unused_rx_flags = rx_ferr_q ^ rx_overrun_q;
`else
    assign rx_avail = 1'b0;
    assign rx_head  = 8'h00;

    logic unused_rx_inputs;
    assign unused_rx_inputs = uart_rx ^ IO_read_strobe;
`endif

    logic unused_tx_flags;
    assign unused_tx_flags = tx_drop_q;

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    always_comb begin
        IO_read_data = 8'hFF;
        case (IO_port_ID)
            PortData:   IO_read_data = rx_avail ? rx_head : 8'h00;
            PortRxStat: IO_read_data = rx_avail ? 8'hFF : 8'h00;
            PortTxStat: IO_read_data = tx_full ? 8'hFF : 8'h00;
            default:    IO_read_data = 8'hFF;
        endcase
    end

endmodule
